// File: rtl/text_vram_sched.sv
// Character RAM scheduler: display fetch slot, font lookup, clear engine and host port.
// Optional blinking cursor under `define TEXT_CURSOR_EN (adds cur_addr port).
module text_vram_sched #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        x_px,
    input  logic [9:0]        y_px,
    input  logic              active,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    input  logic              clr_start,
    input  logic [7:0]        clr_fill,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [11:0]       font_addr,
    input  logic [7:0]        font_data,
    output logic              pixel_on,
    output logic              pixel_valid
`ifdef TEXT_CURSOR_EN
    ,
    input  logic [ADDR_W-1:0] cur_addr
`endif
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COLS * ROWS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
    logic [7:0]        fill_q;

    logic              slot;
    logic [ADDR_W-1:0] disp_addr;
    logic              gnt_disp, gnt_clr, gnt_host;
    logic              in_range;

    logic              slot_d1, slot_d2;
    logic              act_d1, act_d2, act_d3;
    logic [3:0]        line_d1;
    logic [7:0]        shreg;
    logic              cur_hit;

    // Constant COLS unrolls into a fixed set of shifted adds.
    function automatic logic [ADDR_W-1:0] mul_cols(input logic [5:0] row);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (COLS[i])
                acc = acc + (ADDR_W'(row) << i);
        end
        return acc;
    endfunction

    assign slot      = active && (x_px[2:0] == 3'd0);
    assign disp_addr = mul_cols(y_px[9:4]) + ADDR_W'(x_px[9:3]);
    assign in_range  = (wr_addr <= LAST);

    assign gnt_disp = slot;
    assign gnt_clr  = !slot && (state == CLEAR);
    assign gnt_host = !slot && (state == IDLE) && wr_req && !wr_ack;

    assign clr_busy = (state == CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            clr_cnt <= '0;
            fill_q  <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
            if (state == IDLE && clr_start)
                fill_q <= clr_fill;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        unique case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nx   = CLEAR;
                    clr_cnt_nx = '0;
                end
            end
            CLEAR: begin
                if (gnt_clr) begin
                    clr_cnt_nx = clr_cnt + 1'b1;
                    if (clr_cnt == LAST) begin
                        state_nx   = IDLE;
                        clr_cnt_nx = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // RAM port mux; reset forces the port quiet without waiting for a clock.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!rst) begin
            unique case (1'b1)
                gnt_disp: ram_addr = disp_addr;
                gnt_clr: begin
                    ram_we    = 1'b1;
                    ram_addr  = clr_cnt;
                    ram_wdata = fill_q;
                end
                gnt_host: begin
                    ram_we    = in_range;
                    ram_addr  = wr_addr;
                    ram_wdata = wr_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= gnt_host;
            wr_err <= gnt_host && !in_range;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_d1 <= 1'b0;
            slot_d2 <= 1'b0;
            act_d1  <= 1'b0;
            act_d2  <= 1'b0;
            act_d3  <= 1'b0;
            line_d1 <= '0;
            shreg   <= '0;
        end else begin
            slot_d1 <= slot;
            slot_d2 <= slot_d1;
            act_d1  <= active;
            act_d2  <= act_d1;
            act_d3  <= act_d2;
            line_d1 <= y_px[3:0];
            if (slot_d2)
                shreg <= font_data;
            else
                shreg <= {shreg[6:0], 1'b0};
        end
    end

    assign font_addr = rst ? 12'd0 : {ram_rdata, line_d1};

`ifdef TEXT_CURSOR_EN
    logic [ADDR_W-1:0] cell_d1, cell_d2, cell_d3;
    logic [3:0]        line_d2, line_d3;
    logic [5:0]        frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_d1   <= '0;
            cell_d2   <= '0;
            cell_d3   <= '0;
            line_d2   <= '0;
            line_d3   <= '0;
            frame_cnt <= '0;
        end else begin
            if (slot)
                cell_d1 <= disp_addr;
            if (slot_d1)
                cell_d2 <= cell_d1;
            line_d2 <= line_d1;
            if (slot_d2) begin
                cell_d3 <= cell_d2;
                line_d3 <= line_d2;
            end
            if (active && x_px == 10'd0 && y_px == 10'd0)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign cur_hit = (cell_d3 == cur_addr) && (line_d3[3:1] == 3'b111)
                     && frame_cnt[5];
`else
    assign cur_hit = 1'b0;
`endif

    assign pixel_valid = act_d3;
    assign pixel_on    = act_d3 && (shreg[7] ^ cur_hit);

endmodule

// File: tb/tb_text_vram_sched.sv
// Directed bench for text_vram_sched with behavioural character RAM and font ROM.
module tb_text_vram_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x_px, y_px;
    logic        active;
    logic        wr_req;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack, wr_err;
    logic        clr_start;
    logic [7:0]  clr_fill;
    logic        clr_busy;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic        pixel_on, pixel_valid;

    logic [7:0]  mem [0:4095];
    logic        pre_en;
    logic [11:0] pre_addr;
    logic [7:0]  pre_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    text_vram_sched dut (
        .clk(clk), .rst(rst), .x_px(x_px), .y_px(y_px), .active(active),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .clr_start(clr_start), .clr_fill(clr_fill), .clr_busy(clr_busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .font_addr(font_addr), .font_data(font_data),
        .pixel_on(pixel_on), .pixel_valid(pixel_valid)
    );

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_addr] <= pre_data;
        else if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(posedge clk) begin
        case (font_addr)
            12'h410: font_data <= 8'h81;
            12'h420: font_data <= 8'h3C;
            default: font_data <= 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_pix(input int p);
        logic [7:0] g;
        if (p < 8) begin
            g = 8'h81;
            return g[7-p];
        end else if (p < 16) begin
            g = 8'h3C;
            return g[15-p];
        end
        return 1'b0;
    endfunction

    int wcnt, bad, busy_n, ack_at, host_at, nwr;
    logic [11:0] host_addr;

    initial begin
        rst = 1'b1; x_px = '0; y_px = '0; active = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        clr_start = 1'b0; clr_fill = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;

        @(negedge clk);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_clr_busy", clr_busy, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_font_addr", font_addr, 0);
        check("rst_pixel_on", pixel_on, 0);
        check("rst_pixel_valid", pixel_valid, 0);

        for (int a = 0; a < 2400; a++) begin
            next();
            pre_en   = 1'b1;
            pre_addr = 12'(a);
            pre_data = (a == 0) ? 8'h41 : (a == 1) ? 8'h42 : 8'h00;
        end
        next();
        pre_en = 1'b0;
        rst    = 1'b0;
        next();

        // Glyph fetch and serialisation for cells 0 and 1 of row 0
        for (int k = 0; k < 20; k++) begin
            next();
            x_px   = 10'(k);
            y_px   = 10'd0;
            active = (k < 16);
            @(negedge clk);
            if (k == 0) begin
                check("slot_ram_addr", ram_addr, 0);
                check("slot_ram_we", ram_we, 0);
            end
            if (k == 1)
                check("font_addr", font_addr, 12'h410);
            if (k >= 3) begin
                check("pixel_valid", pixel_valid, (k - 3) < 16);
                check("pixel_on", pixel_on, exp_pix(k - 3));
            end
        end

        // Address generation at corners
        next();
        x_px = 10'd632; y_px = 10'd479; active = 1'b1;
        @(negedge clk);
        check("addr_last", ram_addr, 2399);
        next();
        x_px = 10'd8; y_px = 10'd16;
        @(negedge clk);
        check("addr_81", ram_addr, 81);
        next();
        active = 1'b0;
        repeat (4) next();

        // Host write first presented on a slot cycle
        next();
        x_px = 10'd8; y_px = 10'd0; active = 1'b1;
        wr_req = 1'b1; wr_addr = 12'd5; wr_data = 8'h42;
        @(negedge clk);
        check("defer_we", ram_we, 0);
        check("defer_addr", ram_addr, 1);
        next();
        x_px = 10'd9;
        @(negedge clk);
        check("hw_we", ram_we, 1);
        check("hw_addr", ram_addr, 5);
        check("hw_data", ram_wdata, 8'h42);
        check("hw_ack_early", wr_ack, 0);
        next();
        x_px = 10'd10;
        @(negedge clk);
        check("hw_ack", wr_ack, 1);
        check("hw_err", wr_err, 0);
        check("hw_no_reaccept", ram_we, 0);
        next();
        wr_req = 1'b0; active = 1'b0;
        @(negedge clk);
        check("hw_ack_drop", wr_ack, 0);
        check("hw_mem5", mem[5], 8'h42);

        // Out-of-range host write
        next();
        wr_req = 1'b1; wr_addr = 12'd2400; wr_data = 8'h99;
        @(negedge clk);
        check("oor_we", ram_we, 0);
        next();
        @(negedge clk);
        check("oor_ack", wr_ack, 1);
        check("oor_err", wr_err, 1);
        check("oor_we2", ram_we, 0);
        next();
        wr_req = 1'b0;

        // Full clear in blanking with a pending host write
        wcnt = 0; bad = 0; busy_n = 0; ack_at = -1; host_at = -1;
        host_addr = '0;
        for (int i = 0; i < 2410; i++) begin
            next();
            clr_start = (i == 0) || (i == 50);
            clr_fill  = (i == 50) ? 8'h33 : 8'h20;
            wr_req    = (i >= 1) && (ack_at < 0);
            wr_addr   = 12'd7;
            wr_data   = 8'h55;
            @(negedge clk);
            if (clr_busy)
                busy_n++;
            if (ram_we) begin
                if (clr_busy) begin
                    if (ram_addr != 12'(wcnt) || ram_wdata != 8'h20)
                        bad++;
                    wcnt++;
                end else begin
                    host_at   = i;
                    host_addr = ram_addr;
                end
            end
            if (wr_ack && ack_at < 0)
                ack_at = i;
        end
        clr_start = 1'b0;
        wr_req    = 1'b0;
        check("clr_busy_cycles", busy_n, 2400);
        check("clr_writes", wcnt, 2400);
        check("clr_bad_writes", bad, 0);
        check("clr_host_at", host_at, 2401);
        check("clr_host_addr", host_addr, 7);
        check("clr_ack_at", ack_at, 2402);
        check("clr_mem0", mem[0], 8'h20);
        check("clr_mem2399", mem[2399], 8'h20);
        check("clr_mem7", mem[7], 8'h55);

        // Reset in the middle of a clear
        next();
        clr_start = 1'b1; clr_fill = 8'h66;
        for (int j = 0; j <= 100; j++) begin
            next();
            clr_start = 1'b0;
            wr_req = 1'b1; wr_addr = 12'd9; wr_data = 8'h77;
            @(negedge clk);
            if (j == 100) begin
                check("mid_addr", ram_addr, 100);
                check("mid_we", ram_we, 1);
            end
        end
        #1;
        rst = 1'b1;
        #1;
        check("arst_busy", clr_busy, 0);
        check("arst_we", ram_we, 0);
        check("arst_ack", wr_ack, 0);
        check("arst_pixel", pixel_on, 0);
        wr_req = 1'b0;
        repeat (3) next();
        rst = 1'b0;
        nwr = 0;
        for (int j = 0; j < 20; j++) begin
            next();
            @(negedge clk);
            if (ram_we)
                nwr++;
        end
        check("post_rst_writes", nwr, 0);
        check("post_rst_busy", clr_busy, 0);
        check("abort_mem99", mem[99], 8'h66);
        check("abort_mem100", mem[100], 8'h20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
